// File: rtl/seq_decoder.sv
// -----------------------------------------------------------------------------
// seq_decoder
//
// Registered N_IN-to-2**N_IN decoder with valid/ready handshakes on both sides.
// Each accepted code produces one output beat, except in sweep mode, where it
// produces a run of one-hot beats from the start code up to the top code.
//
// Modes (sampled only when a code is accepted):
//   00 one-hot      out_dec[k] = (k == in_code)
//   01 thermometer  out_dec[k] = (k <= in_code)
//   10 sweep        one-hot beats for in_code, in_code+1, ..., OUT_W-1
//   11 reserved     decoded as one-hot
//
// Parameters:
//   N_IN   code width in bits, legal range 2..6
//   OUT_W  decoded width, fixed at 2**N_IN
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         block enable; gates acceptance of new codes only
//   in_valid   input code present
//   in_ready   block can accept a code this cycle
//   in_code    code to decode, or sweep start code
//   mode       decode mode, see above
//   out_valid  out_dec/out_code hold a valid beat
//   out_ready  downstream accepts the beat
//   out_dec    registered decoded word
//   out_code   code that produced out_dec
//   busy       high while a sweep is in progress
// -----------------------------------------------------------------------------
module seq_decoder #(
  parameter int N_IN = 4,
  localparam int OUT_W = 2**N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_code,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_dec,
  output logic [N_IN-1:0]  out_code,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             accept;
  logic             xfer;
  logic             sweep_last;
  logic [N_IN:0]    thermo_shift;
  logic [OUT_W-1:0] onehot_dec;
  logic [OUT_W-1:0] thermo_dec;
  logic [OUT_W-1:0] load_dec;

  assign accept     = in_valid & in_ready;
  assign xfer       = out_valid & out_ready;
  // A sweep never wraps, so the all-ones code is always its final beat.
  assign sweep_last = &out_code;

  // Decode the incoming code. The thermometer shift is one bit wider than the
  // code so that the top code shifts every ones bit out and inverts to all ones.
  always_comb begin
    onehot_dec          = '0;
    onehot_dec[in_code] = 1'b1;
    thermo_shift        = {1'b0, in_code} + (N_IN+1)'(1);
    thermo_dec          = ~({OUT_W{1'b1}} << thermo_shift);
    load_dec            = (mode == 2'b01) ? thermo_dec : onehot_dec;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. HOLD can accept a new code in the same cycle its beat
  // leaves, so it re-enters HOLD or SWEEP without a bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (mode == 2'b10) ? SWEEP : HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          state_nxt = (mode == 2'b10) ? SWEEP : HOLD;
        end else if (xfer) begin
          state_nxt = IDLE;
        end
      end
      SWEEP: begin
        if (xfer && sweep_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs derived from state. A beat is held exactly when not IDLE, and a
  // sweep blocks new codes until its final beat has left.
  always_comb begin
    out_valid = (state != IDLE);
    busy      = (state == SWEEP);
    in_ready  = en & (state != SWEEP) & (~out_valid | out_ready);
  end

  // Output beat register. A new code loads the first beat; during a sweep
  // each transfer advances to the next code, shifting the one-hot bit up.
  // Nothing changes while a beat waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dec  <= '0;
      out_code <= '0;
    end else if (accept) begin
      out_dec  <= load_dec;
      out_code <= in_code;
    end else if (xfer && (state == SWEEP) && !sweep_last) begin
      out_dec  <= out_dec << 1;
      out_code <= out_code + N_IN'(1);
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// -----------------------------------------------------------------------------
// tb_seq_decoder
//
// Self-checking bench for seq_decoder. Directed scenarios check fixed values;
// a randomized run is compared against a queue-based model of the beats that
// each accepted request must produce. A second instance built with N_IN=2
// checks the narrow configuration.
// -----------------------------------------------------------------------------
module tb_seq_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_dec;
  logic [3:0]  out_code;
  logic        busy;

  logic        s_en;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [1:0]  s_in_code;
  logic [1:0]  s_mode;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [3:0]  s_out_dec;
  logic [1:0]  s_out_code;
  logic        s_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_decoder #(.N_IN(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dec   (out_dec),
    .out_code  (out_code),
    .busy      (busy)
  );

  seq_decoder #(.N_IN(2)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (s_en),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_code   (s_in_code),
    .mode      (s_mode),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_dec   (s_out_dec),
    .out_code  (s_out_code),
    .busy      (s_busy)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted request expands into its list of beats.
  typedef struct packed {
    logic [15:0] dec;
    logic [3:0]  code;
    logic        sweep;
  } beat_t;

  beat_t q[$];

  function automatic logic [15:0] ref_onehot(input int c);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = (k == c);
    return r;
  endfunction

  function automatic logic [15:0] ref_thermo(input int c);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = (k <= c);
    return r;
  endfunction

  task automatic push_request(input logic [1:0] m, input logic [3:0] c);
    if (m == 2'b10) begin
      for (int v = int'(c); v < 16; v++) q.push_back('{ref_onehot(v), 4'(v), 1'b1});
    end else if (m == 2'b01) begin
      q.push_back('{ref_thermo(int'(c)), c, 1'b0});
    end else begin
      q.push_back('{ref_onehot(int'(c)), c, 1'b0});
    end
  endtask

  // A code is taken when enabled and either nothing is held, or a non-sweep
  // beat is leaving this cycle.
  function automatic bit exp_ready();
    return en && (q.size() == 0 || (out_ready && !q[0].sweep));
  endfunction

  // Advance one clock and keep the model in step with the handshakes that
  // occur at that edge.
  task automatic tick();
    bit          acc;
    bit          xf;
    logic [1:0]  m;
    logic [3:0]  c;
    acc = in_valid && exp_ready();
    xf  = (q.size() > 0) && out_ready;
    m   = mode;
    c   = in_code;
    @(posedge clk);
    if (xf) void'(q.pop_front());
    if (acc) push_request(m, c);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
    tests_run++;
    if (out_dec !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_out_dec: got %h, expected 0000", out_dec); end
    tests_run++;
    if (out_code !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_out_code: got %h, expected 0", out_code); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready_en1: got %b, expected 1", in_ready); end
    en = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready_en0: got %b, expected 0", in_ready); end
    en = 1'b1;
    q.delete();
    @(negedge clk);
  endtask

  task automatic test_onehot();
    logic [3:0]  codes [3];
    logic [15:0] exps  [3];
    codes = '{4'd0, 4'd15, 4'd0};
    exps  = '{16'h0001, 16'h8000, 16'h0001};
    en = 1'b1; out_ready = 1'b1; mode = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_code = codes[i];
      tick();
      #1;
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL onehot_valid[%0d]: got %b, expected 1", i, out_valid); end
      tests_run++;
      if (out_dec !== exps[i]) begin tests_failed++; $display("[TB] FAIL onehot_dec[%0d]: got %h, expected %h", i, out_dec, exps[i]); end
      tests_run++;
      if (out_code !== codes[i]) begin tests_failed++; $display("[TB] FAIL onehot_code[%0d]: got %h, expected %h", i, out_code, codes[i]); end
    end
    in_valid = 1'b0;
    tick();
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL onehot_drain: got %b, expected 0", out_valid); end
  endtask

  task automatic test_thermo();
    logic [3:0]  codes [3];
    logic [15:0] exps  [3];
    codes = '{4'd5, 4'd15, 4'd0};
    exps  = '{16'h003F, 16'hFFFF, 16'h0001};
    out_ready = 1'b1; mode = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_code = codes[i];
      tick();
      #1;
      tests_run++;
      if (out_dec !== exps[i]) begin tests_failed++; $display("[TB] FAIL thermo_dec[%0d]: got %h, expected %h", i, out_dec, exps[i]); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    mode = 2'b10; in_code = 4'd12; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    mode = 2'b00; in_code = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL sweep_busy[%0d]: got %b, expected 1", i, busy); end
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL sweep_in_ready[%0d]: got %b, expected 0", i, in_ready); end
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL sweep_valid[%0d]: got %b, expected 1", i, out_valid); end
      tests_run++;
      if (out_dec !== (16'h1000 << i)) begin tests_failed++; $display("[TB] FAIL sweep_dec[%0d]: got %h, expected %h", i, out_dec, 16'h1000 << i); end
      tests_run++;
      if (out_code !== 4'(12 + i)) begin tests_failed++; $display("[TB] FAIL sweep_code[%0d]: got %h, expected %h", i, out_code, 4'(12 + i)); end
      if (i == 3) in_valid = 1'b0;
      tick();
    end
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL sweep_end_busy: got %b, expected 0", busy); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL sweep_end_valid: got %b, expected 0", out_valid); end
  endtask

  task automatic test_sweep_top_stall();
    mode = 2'b10; in_code = 4'd15; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_dec !== 16'h8000 || out_code !== 4'd15) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b dec=%h code=%h, expected valid=1 dec=8000 code=f", i, out_valid, out_dec, out_code);
      end
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_busy[%0d]: got %b, expected 1", i, busy); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_dec !== 16'h8000) begin tests_failed++; $display("[TB] FAIL stall_release_dec: got %h, expected 8000", out_dec); end
    tick();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_single_beat: got valid=%b busy=%b, expected valid=0 busy=0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    mode = 2'b10; in_code = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #1;
    tests_run++;
    if (out_code !== 4'd9 || out_dec !== 16'h0200) begin
      tests_failed++;
      $display("[TB] FAIL midsweep_pos: got code=%h dec=%h, expected code=9 dec=0200", out_code, out_dec);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_dec !== 16'h0000 || out_code !== 4'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midsweep_reset: got valid=%b dec=%h code=%h busy=%b, expected all 0", out_valid, out_dec, out_code, busy);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL midsweep_no_replay[%0d]: got valid=%b busy=%b, expected 0 0", i, out_valid, busy);
      end
      tick();
    end
  endtask

  task automatic test_enable();
    en = 1'b0; in_valid = 1'b1; mode = 2'b00; in_code = 4'd7; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL enable_in_ready[%0d]: got %b, expected 0", i, in_ready); end
      tick();
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL enable_no_beat[%0d]: got %b, expected 0", i, out_valid); end
    end
    in_valid = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en        = ($urandom_range(0, 7) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      mode      = 2'($urandom_range(0, 3));
      in_code   = (mode == 2'b10) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      tests_run++;
      if (in_ready !== exp_ready()) begin tests_failed++; $display("[TB] FAIL rand_in_ready[%0d]: got %b, expected %b", n, in_ready, exp_ready()); end
      tests_run++;
      if (out_valid !== (q.size() > 0)) begin tests_failed++; $display("[TB] FAIL rand_valid[%0d]: got %b, expected %b", n, out_valid, q.size() > 0); end
      tests_run++;
      if (busy !== (q.size() > 0 && q[0].sweep)) begin tests_failed++; $display("[TB] FAIL rand_busy[%0d]: got %b, expected %b", n, busy, q.size() > 0 && q[0].sweep); end
      if (q.size() > 0) begin
        tests_run++;
        if (out_dec !== q[0].dec || out_code !== q[0].code) begin
          tests_failed++;
          $display("[TB] FAIL rand_beat[%0d]: got dec=%h code=%h, expected dec=%h code=%h", n, out_dec, out_code, q[0].dec, q[0].code);
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; en = 1'b1;
    for (int k = 0; k < 40 && q.size() > 0; k++) tick();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rand_drain: got valid=%b busy=%b, expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_small();
    s_mode = 2'b00; s_in_code = 2'd3; s_in_valid = 1'b1; s_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    tests_run++;
    if (s_out_valid !== 1'b1 || s_out_dec !== 4'b1000 || s_out_code !== 2'd3) begin
      tests_failed++;
      $display("[TB] FAIL small_onehot: got valid=%b dec=%b code=%0d, expected valid=1 dec=1000 code=3", s_out_valid, s_out_dec, s_out_code);
    end
    s_mode = 2'b01; s_in_code = 2'd1; s_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    tests_run++;
    if (s_out_dec !== 4'b0011) begin tests_failed++; $display("[TB] FAIL small_thermo: got %b, expected 0011", s_out_dec); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = '0; mode = '0; out_ready = 1'b0;
    s_en = 1'b1; s_in_valid = 1'b0; s_in_code = '0; s_mode = '0; s_out_ready = 1'b1;
    test_reset();
    test_onehot();
    test_thermo();
    test_sweep();
    test_sweep_top_stall();
    test_reset_mid_sweep();
    test_enable();
    test_random();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
